// File: rtl/bus_mux_pkg.sv
//------------------------------------------------------------------------------
// Module   : bus_mux_pkg
// Brief    : Shared constants, FSM state type and helpers for bus_mux_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bus_mux_pkg;

    localparam int NREQ = 16;
    localparam int SW   = 4;
    localparam int DW   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_mux_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : bus_mux_arbiter_if
// Brief    : Requester handshake plus shared read-mux control/data bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_mux_arbiter_if;
    import bus_mux_pkg::*;

    logic            arb_en;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   rdata;
    logic [SW-1:0]   mux_sel;
    logic            mux_en;
    logic [DW-1:0]   mux_out;
    logic [SW-1:0]   gnt_id;
    logic            busy;

    // Arbiter side: drives the mux controls and the requester acks.
    modport master (
        input  arb_en, req, mux_out,
        output ack, rdata, mux_sel, mux_en, gnt_id, busy
    );

    modport slave (
        output arb_en, req, mux_out,
        input  ack, rdata, mux_sel, mux_en, gnt_id, busy
    );

endinterface

`default_nettype wire

// File: rtl/bus_mux_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first set bit after ptr, wrapping.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
    import bus_mux_pkg::*;
(
    input  wire logic [NREQ-1:0] vec,
    input  wire logic [SW-1:0]   ptr,
    output logic      [SW-1:0]   idx,
    output logic                 any
);

    logic [SW-1:0]   w_shift;
    logic [NREQ-1:0] w_rot;
    logic [SW-1:0]   w_src;
    logic [SW-1:0]   w_first;

    assign w_shift = ptr + SW'(1);

    // Rotate so that position ptr+1 lands on bit 0; index math wraps at SW bits.
    always_comb begin
        w_rot = '0;
        w_src = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_src    = SW'(i) + w_shift;
            w_rot[i] = vec[w_src];
        end
    end

    always_comb begin
        w_first = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_first = SW'(i);
            end
        end
    end

    assign idx = w_first + w_shift;
    assign any = |vec;

endmodule

`default_nettype wire

// File: rtl/bus_mux_arbiter.sv
//------------------------------------------------------------------------------
// Module   : bus_mux_arbiter
// Brief    : Round-robin owner of the shared 16:1 read mux; captures and acks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_mux_arbiter
    import bus_mux_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    bus_mux_arbiter_if.master  bus
);

    state_t          r_state;
    logic [SW-1:0]   r_ptr;
    logic [SW-1:0]   r_gnt_id;
    logic [SW-1:0]   r_mux_sel;
    logic            r_mux_en;
    logic [NREQ-1:0] r_ack;
    logic [DW-1:0]   r_rdata;
    logic            r_busy;

    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_pick_vec;
    logic [SW-1:0]   w_pick_ptr;
    logic [SW-1:0]   w_pick_idx;
    logic            w_pick_any;

    // The current winner may still hold req, so it is masked out of the
    // back-to-back decision; the pointer used is the one being committed now.
    assign w_cand     = bus.req & ~onehot(r_gnt_id);
    assign w_pick_vec = (r_state == CAPTURE) ? w_cand   : bus.req;
    assign w_pick_ptr = (r_state == CAPTURE) ? r_gnt_id : r_ptr;

    rr_pick u_rr_pick (
        .vec (w_pick_vec),
        .ptr (w_pick_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= SW'(NREQ - 1);
            r_gnt_id  <= '0;
            r_mux_sel <= '0;
            r_mux_en  <= 1'b0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (bus.arb_en && w_pick_any) begin
                        r_gnt_id  <= w_pick_idx;
                        r_mux_sel <= w_pick_idx;
                        r_mux_en  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= SELECT;
                    end else begin
                        r_mux_en  <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                SELECT: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_rdata <= bus.mux_out;
                    r_ack   <= onehot(r_gnt_id);
                    r_ptr   <= r_gnt_id;
                    if (bus.arb_en && w_pick_any) begin
                        r_gnt_id  <= w_pick_idx;
                        r_mux_sel <= w_pick_idx;
                        r_state   <= SELECT;
                    end else begin
                        r_mux_en  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mux_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = r_ack;
    assign bus.rdata   = r_rdata;
    assign bus.mux_sel = r_mux_sel;
    assign bus.mux_en  = r_mux_en;
    assign bus.gnt_id  = r_gnt_id;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bus_mux_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_mux_arbiter
// Brief    : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_mux_arbiter;
    import bus_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] din [16];

    int n_tests = 0;
    int n_fail  = 0;

    bus_mux_arbiter_if bus ();

    bus_mux_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mux_out = bus.mux_en ? din[bus.mux_sel] : 8'h00;

    // Transaction-level reference: edges remaining until capture, last winner, pointer.
    int          m_left;
    int          m_win;
    int          m_ptr;
    logic [15:0] m_ack;
    logic [7:0]  m_rdata;

    function automatic int pick(input logic [15:0] v, input int p);
        for (int k = 1; k <= 16; k++) begin
            if (v[(p + k) % 16]) return (p + k) % 16;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_left = 0; m_win = 0; m_ptr = 15; m_ack = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [15:0] cand;
        if (!rst_n) return;
        m_ack = '0;
        if (m_left == 1) begin
            m_ack   = 16'(1) << m_win;
            m_rdata = din[m_win];
            m_ptr   = m_win;
            cand    = bus.req & ~m_ack;
            if (bus.arb_en && cand != 0) begin
                m_win = pick(cand, m_ptr); m_left = 2;
            end else begin
                m_left = 0;
            end
        end else if (m_left == 2) begin
            m_left = 1;
        end else if (bus.arb_en && bus.req != 0) begin
            m_win = pick(bus.req, m_ptr); m_left = 2;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] req;
        logic        arb_en;
        logic [15:0] ack;
        logic [7:0]  rdata;
        logic [3:0]  sel;
        logic        en;
        logic        busy;
    } vec_t;

    vec_t tbl [5];

    int ack_t [$];
    int ack_i [$];
    int en_h  [$];

    initial begin
        for (int i = 0; i < 16; i++) din[i] = 8'(i);
        bus.req = '0;
        bus.arb_en = 1'b1;
        model_reset();

        // Reset then idle
        do_reset();
        chk("reset_gnt_id", 32'(bus.gnt_id), 0);
        chk("reset_sel", 32'(bus.mux_sel), 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_ack", 32'(bus.ack), 0);
            chk("idle_en", 32'(bus.mux_en), 0);
            chk("idle_rdata", 32'(bus.rdata), 0);
            chk("idle_busy", 32'(bus.busy), 0);
        end

        // Single request, table-driven
        din[5] = 8'hA5;
        tbl[0] = '{16'h0020, 1'b1, 16'h0000, 8'h00, 4'd5, 1'b1, 1'b1};
        tbl[1] = '{16'h0020, 1'b1, 16'h0000, 8'h00, 4'd5, 1'b1, 1'b1};
        tbl[2] = '{16'h0020, 1'b1, 16'h0020, 8'hA5, 4'd5, 1'b0, 1'b0};
        tbl[3] = '{16'h0000, 1'b1, 16'h0000, 8'hA5, 4'd5, 1'b0, 1'b0};
        tbl[4] = '{16'h0000, 1'b1, 16'h0000, 8'hA5, 4'd5, 1'b0, 1'b0};
        for (int v = 0; v < 5; v++) begin
            bus.req = tbl[v].req;
            bus.arb_en = tbl[v].arb_en;
            tick();
            chk($sformatf("tbl%0d_ack", v), 32'(bus.ack), 32'(tbl[v].ack));
            chk($sformatf("tbl%0d_rdata", v), 32'(bus.rdata), 32'(tbl[v].rdata));
            chk($sformatf("tbl%0d_sel", v), 32'(bus.mux_sel), 32'(tbl[v].sel));
            chk($sformatf("tbl%0d_en", v), 32'(bus.mux_en), 32'(tbl[v].en));
            chk($sformatf("tbl%0d_busy", v), 32'(bus.busy), 32'(tbl[v].busy));
        end
        din[5] = 8'h05;

        // All 16 requesting continuously
        do_reset();
        bus.req = 16'hFFFF;
        ack_t.delete(); ack_i.delete();
        for (int c = 0; c < 60 && ack_t.size() < 17; c++) begin
            tick();
            if (bus.ack != 0) begin
                chk("all_ack_onehot", 32'($onehot(bus.ack)), 1);
                for (int b = 0; b < 16; b++) if (bus.ack[b]) ack_i.push_back(b);
                ack_t.push_back(c);
                chk("all_rdata", 32'(bus.rdata), 32'((ack_t.size() - 1) % 16));
            end
        end
        chk("all_grant_count", 32'(ack_t.size()), 17);
        for (int g = 0; g < ack_i.size(); g++) begin
            chk($sformatf("all_order%0d", g), 32'(ack_i[g]), 32'(g % 16));
            if (g > 0) chk("all_spacing", 32'(ack_t[g] - ack_t[g-1]), 2);
        end
        bus.req = '0;

        // Sole persistent requester
        do_reset();
        bus.req = 16'h8000;
        ack_t.delete(); en_h.delete();
        for (int c = 0; c < 20; c++) begin
            tick();
            en_h.push_back(int'(bus.mux_en));
            if (bus.ack != 0) begin
                chk("sole_ack", 32'(bus.ack), 32'h8000);
                chk("sole_rdata", 32'(bus.rdata), 32'h0F);
                ack_t.push_back(c);
            end
        end
        chk("sole_ack_count", 32'(ack_t.size() >= 4), 1);
        for (int g = 1; g < ack_t.size(); g++)
            chk("sole_period", 32'(ack_t[g] - ack_t[g-1]), 3);
        if (ack_t.size() > 0 && ack_t[0] + 2 < en_h.size()) begin
            chk("sole_en0", 32'(en_h[ack_t[0]]), 0);
            chk("sole_en1", 32'(en_h[ack_t[0] + 1]), 1);
            chk("sole_en2", 32'(en_h[ack_t[0] + 2]), 1);
        end
        bus.req = '0;

        // arb_en dropped during SELECT
        do_reset();
        bus.req = 16'h0018;
        tick();
        chk("arb_sel3", 32'(bus.mux_sel), 3);
        chk("arb_en_sel", 32'(bus.mux_en), 1);
        bus.arb_en = 1'b0;
        tick();
        tick();
        chk("arb_ack3", 32'(bus.ack), 32'h0008);
        chk("arb_en_off", 32'(bus.mux_en), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("arb_hold_en", 32'(bus.mux_en), 0);
            chk("arb_hold_ack", 32'(bus.ack), 0);
            chk("arb_hold_busy", 32'(bus.busy), 0);
        end
        bus.arb_en = 1'b1;
        tick();
        chk("arb_sel4", 32'(bus.mux_sel), 4);
        chk("arb_en4", 32'(bus.mux_en), 1);
        bus.req = '0;

        // Async reset in SELECT
        do_reset();
        bus.req = 16'h0004;
        tick();
        chk("ar_sel2", 32'(bus.mux_sel), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_en_drop", 32'(bus.mux_en), 0);
        chk("ar_ack_drop", 32'(bus.ack), 0);
        chk("ar_busy_drop", 32'(bus.busy), 0);
        bus.req = 16'h0001;
        tick();
        chk("ar_ack_in_rst", 32'(bus.ack), 0);
        rst_n = 1'b1;
        tick();
        chk("ar_sel0", 32'(bus.mux_sel), 0);
        chk("ar_en0", 32'(bus.mux_en), 1);
        tick();
        chk("ar_no_ack", 32'(bus.ack), 0);
        tick();
        chk("ar_ack0", 32'(bus.ack), 32'h0001);
        bus.req = '0;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.req = '0;
            bus.arb_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) din[$urandom_range(0, 15)] = 8'($urandom);
            tick();
            chk("rnd_ack", 32'(bus.ack), 32'(m_ack));
            chk("rnd_rdata", 32'(bus.rdata), 32'(m_rdata));
            chk("rnd_sel", 32'(bus.mux_sel), 32'(m_win));
            chk("rnd_gnt", 32'(bus.gnt_id), 32'(m_win));
            chk("rnd_en", 32'(bus.mux_en), 32'(m_left != 0));
            chk("rnd_busy", 32'(bus.busy), 32'(m_left != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_mux_arbiter.md
Name: bus_mux_arbiter

Overview:
- Round-robin controller that shares the 16-way, 8-bit tri-state read mux among 16 requesters.
- Each cycle it picks one pending requester and drives that mux's sel/en. It then captures the selected byte into a register and returns it with a one-hot ack to the winner.
- Sits between the RAM bank read ports (requesters) and the shared mux output bus.

Parameters:
- NREQ, 16, number of requesters; must equal 2**SW
- SW, 4, select width driven to the mux
- DW, 8, data width of the mux output

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- arb_en  input  1  global arbitration enable
- req  input  NREQ  level request, one bit per requester
- ack  output  NREQ  one-hot, one-cycle pulse to the winning requester
- rdata  output  DW  captured byte; valid while its ack bit is high, held afterwards
- mux_sel  output  SW  select to the mux
- mux_en  output  1  enable to the mux tri-state buffers
- mux_out  input  DW  mux output bus
- gnt_id  output  SW  index of the current/last winner
- busy  output  1  high in SELECT or CAPTURE

Behaviour:
- Reset (async, rst_n=0), all registers take these values immediately:
  - state=IDLE, ack=0, rdata=0, mux_sel=0, mux_en=0, gnt_id=0, busy=0
  - RR pointer ptr=NREQ-1, so requester 0 has highest priority first.
- Winner function: the first set bit of the candidate vector, searching ptr+1, ptr+2, … with modulo-NREQ wrap.
- FSM states: IDLE, SELECT, CAPTURE. All outputs are registered.
- IDLE:
  - If arb_en and req≠0: register gnt_id=mux_sel=winner(req), mux_en=1, go to SELECT.
  - Otherwise stay; mux_en=0.
- SELECT:
  - One settle cycle; mux_sel and mux_en are held.
  - Always goes to CAPTURE. req and arb_en are ignored here.
- CAPTURE:
  - rdata<=mux_out, ack<=onehot(gnt_id) (visible the following cycle), ptr<=gnt_id.
  - Candidates = req & ~onehot(gnt_id); the current winner is excluded because its req may still be high.
  - If arb_en and candidates≠0: gnt_id=mux_sel=winner(candidates) using the updated ptr, mux_en stays 1, go to SELECT (back-to-back).
  - Otherwise: mux_en=0, mux_sel holds, go to IDLE.
- Latency and throughput:
  - req sampled in IDLE at edge T gives mux_en/mux_sel at T+1, captured at edge T+2, ack and rdata visible after T+2.
  - Back-to-back grants every 2 cycles.
  - A sole continuously-requesting master is regranted every 3 cycles.
- Requester protocol: drop req in the cycle after ack, or it is re-queued behind the other pending requesters.
- Boundary conditions:
  - arb_en low during SELECT/CAPTURE: the in-flight transaction completes with ack and rdata; no new grant is made.
  - req withdrawn after grant: the transaction still completes and ack is still issued.
  - ptr=15 with winner 0: the wrap is correct.
  - Simultaneous requests from all 16 requesters: each is served exactly once per 16 grants.
  - rst_n asserted mid-SELECT: mux_en and ack drop immediately and no ack is issued.
- Arithmetic: pointer arithmetic is modulo NREQ at width SW; there is no overflow state.

Decomposition:
- Shared package bus_mux_pkg:
  - constants NREQ, SW, DW
  - state enum {IDLE, SELECT, CAPTURE}
- Sub-module rr_pick: purely combinational.
  - Inputs: vec[NREQ], ptr[SW].
  - Outputs: idx[SW], any.
  - Implemented as a rotate-by-(ptr+1), priority encode, then add back modulo NREQ.
  - Instantiated once; the candidate-vector mux sits in the parent.
- The parent holds the FSM, ptr, and the capture/ack registers.

Test Plan:
- Reset then idle: rst_n low→high with req=0 → ack=0, mux_en=0, rdata=0, busy=0 for 10 cycles.
- Single request: req=16'h0020 held, mux model drives in5=8'hA5.
  - mux_sel=5 and mux_en=1 one cycle after sampling.
  - ack=16'h0020 two cycles after mux_en rises, rdata=8'hA5.
  - req dropped → IDLE.
- All 16 requesting continuously from reset, inN=N:
  - Grant order 0,1,…,15,0 with acks every 2 cycles.
  - rdata sequence 0x00…0x0F.
- Sole persistent requester: req=16'h8000 never dropped → ack[15] every 3 cycles; mux_en toggles 1,1,0.
- arb_en drops during SELECT of requester 3 with req=16'h0018 → ack=16'h0008 still issued, no grant to 4, IDLE until arb_en=1.
- Async reset mid-transaction: rst_n low during SELECT → mux_en=0 and ack=0 within the same cycle. After release with req=16'h0001 → requester 0 granted first (ptr=15).
